bitmap_loader: RTL
==================

Name: bitmap_loader

Overview:
- Upstream feeder for the compare/accumulate stage. Fetches one 64-row x 24-column glyph bitmap from pixel memory, one row per read.
- Packs the rows into the 1536-bit bitmap bus and pulses wren for one cycle.
- Holds the bus stable until the compare stage reports done, then returns to idle and pulses frame_done.

Parameters:
- ROWS, 64, rows per bitmap; the bitmap bus is ROWS*COLS bits wide.
- COLS, 24, pixels per row, equal to the mem_data width.
- ADDR_W, 16, memory address width.
- ROW_STRIDE, 1, address increment between consecutive rows.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load a bitmap from base_addr.
- base_addr  in  ADDR_W  address of row 0 (top row); sampled on the start cycle.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address, valid while mem_rd=1.
- mem_data  in  COLS  row data; bit COLS-1 is the leftmost pixel.
- mem_valid  in  1  mem_data valid; arrives 1 or more cycles after mem_rd.
- bitmap  out  ROWS*COLS  packed bitmap. Row 0 is at [1535:1512]; row 63 (bottom row) is at [23:0].
- wren  out  1  one-cycle write pulse to the compare stage.
- cmp_done  in  1  compare stage result ready.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the handshake with the compare stage completes.

Behaviour:
- Reset values: state IDLE, bitmap=0, mem_rd=0, mem_addr=0, wren=0, busy=0, frame_done=0, row counter=0.
- Reset is asynchronous and effective in any state. A reset mid-load discards the partial bitmap.
- State machine (state held in registers; outputs driven from registers):
  - IDLE: start=1 latches base_addr, clears the row counter, goes to REQ.
  - REQ: mem_rd=1 for exactly one cycle, mem_addr = base_addr + row*ROW_STRIDE (mod 2^ADDR_W, wraps silently), goes to WAIT.
  - WAIT: on mem_valid=1, writes mem_data into row slot [1535-24*row -: 24] and increments row. If row was 63 goes to WRITE, else goes to REQ.
  - WRITE: wren=1 for one cycle, goes to HOLD.
  - HOLD: waits for cmp_done=1, then goes to IDLE with frame_done=1 on that transition cycle.
- Only one read is outstanding at a time. mem_valid is ignored outside WAIT.
- Latency with 1-cycle memory: start at cycle 0; first mem_rd at cycle 1; wren at cycle 129. Each row costs 2 cycles plus any extra memory latency.
- bitmap is unchanged from the WRITE cycle until the state leaves HOLD. The previous bitmap is kept across IDLE and is overwritten row by row during the next load.
- start while busy=1 is ignored; no queueing.
- cmp_done=1 already high on entry to HOLD completes HOLD in one cycle; this covers a level-held done from the compare stage.
- cmp_done outside HOLD is ignored.
- Simultaneous mem_valid and start in WAIT: the row is captured and start is ignored.

Optional Feature:
- Macro: PIX_INVERT_EN.
- Defined: each row is stored as ~mem_data, for memories where 0 means ink.
- Undefined: rows are stored unmodified.
- All timing is identical in both builds.

Test Plan:
- Memory holds rows 0-2 = 0, rows 3-4 = 24'h3fffff, rows 5-6 = 0, rows 7-61 = 24'h3fffff, rows 62-63 = 0; start with base_addr=0 and 1-cycle memory -> mem_rd addresses 0..63, wren at cycle 129, bitmap[23:0]=0, bitmap[1535:1512]=0, bitmap[1463:1440]=24'h3fffff (row 3).
- Memory latency randomised 1-5 cycles -> bitmap identical to the 1-cycle case, exactly 64 mem_rd pulses, one wren pulse.
- base_addr=16'hFFF0 with ROW_STRIDE=1 -> mem_addr sequence FFF0..FFFF then 0000..002F.
- start pulsed at row 10, and stray mem_valid pulses in REQ -> no restart, no extra capture, final bitmap correct.
- cmp_done held low for 50 cycles after wren -> busy stays 1, bitmap stable; cmp_done=1 -> frame_done pulse next edge, busy=0.
- rst_n low at row 30 -> all outputs at reset values immediately. A new start afterwards loads the full 64 rows from row 0.

Source files
------------

// File: rtl/bitmap_loader.sv
// Glyph bitmap loader: fetches ROWS rows from pixel memory, packs them into one wide bus, then handshakes with the compare stage.
// Optional build macro PIX_INVERT_EN stores each row inverted (for memories where 0 means ink).
module bitmap_loader #(
    parameter int ROWS       = 64,
    parameter int COLS       = 24,
    parameter int ADDR_W     = 16,
    parameter int ROW_STRIDE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [COLS-1:0]        mem_data,
    input  logic                   mem_valid,
    output logic [ROWS*COLS-1:0]   bitmap,
    output logic                   wren,
    input  logic                   cmp_done,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [ADDR_W-1:0]  base_reg, base_next;
    logic [ADDR_W-1:0]  addr_next;
    logic               capture;
    logic [COLS-1:0]    row_data;
    logic [COLS-1:0]    rows_reg [ROWS];

`ifdef PIX_INVERT_EN
    assign row_data = ~mem_data;
`else
    assign row_data = mem_data;
`endif

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        base_next  = base_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    base_next  = base_addr;
                    row_next   = '0;
                    state_next = REQ;
                end
            end
            REQ:  state_next = WAIT;
            WAIT: begin
                if (mem_valid) begin
                    capture = 1'b1;
                    if (row_reg == ROW_W'(ROWS - 1)) begin
                        row_next   = '0;
                        state_next = WRITE;
                    end else begin
                        row_next   = row_reg + 1'b1;
                        state_next = REQ;
                    end
                end
            end
            WRITE: state_next = HOLD;
            HOLD: begin
                if (cmp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Address arithmetic wraps modulo 2^ADDR_W by truncation.
        addr_next = base_next + ADDR_W'(row_next) * ADDR_W'(ROW_STRIDE);
    end

    // All outputs are registered from the next-state decode so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            base_reg   <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            wren       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            base_reg   <= base_next;
            mem_rd     <= (state_next == REQ);
            if (state_next == REQ) begin
                mem_addr <= addr_next;
            end
            wren       <= (state_next == WRITE);
            busy       <= (state_next != IDLE);
            frame_done <= (state_reg == HOLD) && cmp_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                rows_reg[r] <= '0;
            end
        end else if (capture) begin
            rows_reg[row_reg] <= row_data;
        end
    end

    // Row 0 (top) occupies the most significant slice of the bus.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_pack
        assign bitmap[ROWS*COLS-1-gi*COLS -: COLS] = rows_reg[gi];
    end

endmodule
